// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Purpose  : Bundles every datapath <-> hazard controller signal.
//             master : datapath side (drives pipeline status, takes controls)
//             slave  : hazard controller side
//  Ports    : Decode/Execute/Memory/Writeback register addresses and write
//             flags, HI/LO flags, divide start, exception; forwarding
//             selects, stalls, flushes, divider status.
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  // Decode
  logic [REG_AW-1:0] rsD;
  logic [REG_AW-1:0] rtD;
  logic              branchD;
  // Execute
  logic [REG_AW-1:0] rsE;
  logic [REG_AW-1:0] rtE;
  logic [REG_AW-1:0] writeregE;
  logic              regwriteE;
  logic              memtoregE;
  logic              divstartE;
  // Memory / Writeback
  logic [REG_AW-1:0] writeregM;
  logic [REG_AW-1:0] writeregW;
  logic              regwriteM;
  logic              memtoregM;
  logic              regwriteW;
  logic              excM;
  // HI/LO flags: [2] writes HI/LO, [1] HI, [0] LO
  logic [2:0]        flagE;
  logic [2:0]        flagM;
  logic [2:0]        flagW;
  // Controls back to the datapath
  logic              forwardaD;
  logic              forwardbD;
  logic [1:0]        forwardaE;
  logic [1:0]        forwardbE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              flushW;
  logic              div_busy;
  logic              div_done;

  modport master (
    output rsD, rtD, branchD,
    output rsE, rtE, writeregE, regwriteE, memtoregE, divstartE,
    output writeregM, writeregW, regwriteM, memtoregM, regwriteW, excM,
    output flagE, flagM, flagW,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
    input  stallF, stallD, stallE,
    input  flushD, flushE, flushM, flushW,
    input  div_busy, div_done
  );

  modport slave (
    input  rsD, rtD, branchD,
    input  rsE, rtE, writeregE, regwriteE, memtoregE, divstartE,
    input  writeregM, writeregW, regwriteM, memtoregM, regwriteW, excM,
    input  flagE, flagM, flagW,
    output forwardaD, forwardbD, forwardaE, forwardbE,
    output stallF, stallD, stallE,
    output flushD, flushE, flushM, flushW,
    output div_busy, div_done
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Hazard controller for the 5-stage MIPS pipeline. Generates
//             operand forwarding (GPR and HI/LO), load-use and branch stalls,
//             holds F/D/E while a multi-cycle divide occupies Execute, and
//             flushes everything younger than Memory on an exception.
//  Ports    : clk     - clock, all state on rising edge
//             resetn  - asynchronous active-low reset
//             hz      - hazard_ctrl_if.slave, all pipeline status in and
//                       forwarding/stall/flush controls out
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int DIV_CYCLES  = 32,
  parameter bit BRANCH_IN_D = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  hazard_ctrl_if.slave     hz
);

  localparam int               CNT_W     = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  logic [1:0] fwd_a_e;
  logic [1:0] fwd_b_e;
  logic       fwd_a_d;
  logic       fwd_b_d;
  logic       hilo_m;
  logic       hilo_w;
  logic       lwstall;
  logic       brstall;
  logic       divstall;

  // --------------------------------------------------------------------------
  // Execute forwarding
  // --------------------------------------------------------------------------
  // A HI/LO read in E (MFHI/MFLO style: no HI/LO write of its own) takes the
  // newest in-flight HI/LO write that touches the same half.
  assign hilo_m = ~hz.flagE[2] & hz.flagM[2] & (|(hz.flagE[1:0] & hz.flagM[1:0]));
  assign hilo_w = ~hz.flagE[2] & hz.flagW[2] & (|(hz.flagE[1:0] & hz.flagW[1:0]));

  always_comb begin
    fwd_a_e = 2'b00;
    if (hilo_m) begin
      fwd_a_e = 2'b10;
    end else if (hilo_w) begin
      fwd_a_e = 2'b01;
    end else if (hz.rsE == ZERO_REG) begin
      fwd_a_e = 2'b00;
    end else if (hz.regwriteM && (hz.rsE == hz.writeregM)) begin
      fwd_a_e = 2'b10;
    end else if (hz.regwriteW && (hz.rsE == hz.writeregW)) begin
      fwd_a_e = 2'b01;
    end
  end

  always_comb begin
    fwd_b_e = 2'b00;
    if (hz.rtE == ZERO_REG) begin
      fwd_b_e = 2'b00;
    end else if (hz.regwriteM && (hz.rtE == hz.writeregM)) begin
      fwd_b_e = 2'b10;
    end else if (hz.regwriteW && (hz.rtE == hz.writeregW)) begin
      fwd_b_e = 2'b01;
    end
  end

  // --------------------------------------------------------------------------
  // Load-use: the load's data is not available until after Memory
  // --------------------------------------------------------------------------
  assign lwstall = hz.memtoregE & (hz.rtE != ZERO_REG) &
                   ((hz.rtE == hz.rsD) | (hz.rtE == hz.rtD));

  // --------------------------------------------------------------------------
  // Decode-stage branch resolution (optional)
  // --------------------------------------------------------------------------
  generate
    if (BRANCH_IN_D) begin : g_branch_in_d
      logic dep_e;
      logic dep_m;

      assign fwd_a_d = (hz.rsD != ZERO_REG) & (hz.rsD == hz.writeregM) & hz.regwriteM;
      assign fwd_b_d = (hz.rtD != ZERO_REG) & (hz.rtD == hz.writeregM) & hz.regwriteM;

      // ALU result still in E, or load data not ready until end of M
      assign dep_e = hz.regwriteE & (hz.writeregE != ZERO_REG) &
                     ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));
      assign dep_m = hz.memtoregM & (hz.writeregM != ZERO_REG) &
                     ((hz.writeregM == hz.rsD) | (hz.writeregM == hz.rtD));
      assign brstall = hz.branchD & (dep_e | dep_m);
    end else begin : g_branch_in_e
      assign fwd_a_d = 1'b0;
      assign fwd_b_d = 1'b0;
      assign brstall = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Divider occupancy tracker
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle in which divstartE is first seen (IDLE) already counts as the
  // first divide cycle, so BUSY only needs DIV_CYCLES-1 further cycles and
  // the counter is loaded with DIV_CYCLES-2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (hz.excM) begin
      // The divide in E is being squashed: abandon it without completion.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz.divstartE) begin
            state_d = BUSY;
            cnt_d   = CNT_START;
          end
        end
        BUSY: begin
          // divstartE is ignored here: in the final cycle the same DIV is
          // still sitting in E and must leave without retriggering.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign divstall = ((state_q == IDLE) & hz.divstartE) |
                    ((state_q == BUSY) & (cnt_q != '0));

  // --------------------------------------------------------------------------
  // Stall / flush outputs
  // --------------------------------------------------------------------------
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushM = 1'b0;
    hz.flushW = 1'b0;
    if (hz.excM) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushM = 1'b1;
      hz.flushW = 1'b1;
    end else begin
      hz.stallF = lwstall | brstall | divstall;
      hz.stallD = lwstall | brstall | divstall;
      hz.stallE = divstall;
      // While E is held by the divider no bubble may replace it; the
      // load-use/branch condition is simply re-evaluated once E moves.
      hz.flushE = (lwstall | brstall) & ~divstall;
      // E is frozen, so M must receive a bubble instead of a duplicate.
      hz.flushM = divstall;
    end
  end

  assign hz.forwardaD = fwd_a_d;
  assign hz.forwardbD = fwd_b_d;
  assign hz.forwardaE = fwd_a_e;
  assign hz.forwardbE = fwd_b_e;
  assign hz.div_busy  = (state_q != IDLE);
  assign hz.div_done  = done;

endmodule
`default_nettype wire
